// File: rtl/pram_pkg.sv
// Shared definitions for the program-RAM burst arbiter.
// Holds the default widths and the FSM state encoding. Both are used by
// pram_arbiter, and by anything that binds checkers to its debug state output.
package pram_pkg;

    localparam int PRAM_ADDR_W = 16;  // PRAM address width
    localparam int PRAM_DATA_W = 8;   // PRAM data width
    localparam int PRAM_LEN_W  = 8;   // burst length field (length minus one)

    // IDLE  : no owner, waiting for a request
    // BURST : presenting start+k addresses, one per cycle
    // FLUSH : last byte on rd_data together with done, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } pram_state_e;

endpackage

// File: rtl/pram_rr_arb.sv
// Two-way round-robin picker.
//   req0, req1 : request from client 0 / client 1
//   last       : client served by the previous grant (0 or 1)
//   win        : one-hot winner (win[0] = client 0, win[1] = client 1),
//                all zero when nobody requests
// A single requester always wins. On a tie the client that was not served
// last wins.
module pram_rr_arb (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] win
);

    assign win[0] = req0 & (~req1 | last);
    assign win[1] = req1 & (~req0 | ~last);

endmodule

// File: rtl/pram_arbiter.sv
// Burst arbiter giving two clients shared access to a combinational PRAM.
//   clk, rst              : single clock, synchronous active-high reset
//   req0/1, addr0/1, len0/1 : burst requests; addr/len sampled on the grant edge
//                           only (len = byte count minus one)
//   gnt0/1                : owner of the PRAM, high through FLUSH inclusive
//   rd_data, rd_valid0/1  : PRAM data registered once, one byte per cycle
//   done0/1               : one-cycle pulse coincident with the last byte
//   pram_addr, pram_data  : PRAM address out, combinational read data in
//   dbg_state             : current FSM state (pram_state_e encoding)
//
// Handshake: a client requests by holding req high. The request is taken on
// the first rising edge in IDLE where the client wins arbitration, and gnt
// rises after that edge. Once granted, the burst always runs to completion
// (or to reset) regardless of req. Each rd_valid cycle carries exactly one
// byte; there is no back-pressure.
module pram_arbiter
    import pram_pkg::*;
#(
    parameter int ADDR_W = PRAM_ADDR_W,
    parameter int DATA_W = PRAM_DATA_W,
    parameter int LEN_W  = PRAM_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid0,
    output logic              rd_valid1,
    output logic              done0,
    output logic              done1,
    output logic [ADDR_W-1:0] pram_addr,
    input  logic [DATA_W-1:0] pram_data,
    output logic [1:0]        dbg_state
);

    pram_state_e      state;
    logic [LEN_W-1:0] remaining;  // addresses still to present after the current one
    logic             owner;      // client owning the current burst
    logic             last;       // client served by the most recent grant
    logic [1:0]       win;

    pram_rr_arb u_rr (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .win  (win)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rd_valid0 <= 1'b0;
            rd_valid1 <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rd_data   <= '0;
            pram_addr <= '0;
            remaining <= '0;
            owner     <= 1'b0;
            // Pretend client 1 was served last so client 0 wins the first tie.
            last      <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    rd_valid0 <= 1'b0;
                    rd_valid1 <= 1'b0;
                    done0     <= 1'b0;
                    done1     <= 1'b0;
                    // pram_addr is left alone so it holds the last burst address.
                    if (win != 2'b00) begin
                        state     <= ST_BURST;
                        owner     <= win[1];
                        last      <= win[1];
                        gnt0      <= win[0];
                        gnt1      <= win[1];
                        pram_addr <= win[1] ? addr1 : addr0;
                        remaining <= win[1] ? len1 : len0;
                    end
                end
                ST_BURST: begin
                    // The byte for the address presented this cycle appears next cycle.
                    rd_data   <= pram_data;
                    rd_valid0 <= ~owner;
                    rd_valid1 <= owner;
                    if (remaining == '0) begin
                        state <= ST_FLUSH;
                        done0 <= ~owner;
                        done1 <= owner;
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                        // Natural modular increment wraps all-ones to zero.
                        pram_addr <= pram_addr + ADDR_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_IDLE;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    rd_valid0 <= 1'b0;
                    rd_valid1 <= 1'b0;
                    done0     <= 1'b0;
                    done1     <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pram_arbiter.sv
// Testbench for pram_arbiter: directed bursts plus randomized rounds, checked
// against a transaction-level model of arbitration and burst contents.
module tb_pram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic [7:0]  len0, len1;
    logic        gnt0, gnt1;
    logic [7:0]  rd_data;
    logic        rd_valid0, rd_valid1;
    logic        done0, done1;
    logic [15:0] pram_addr;
    logic [7:0]  pram_data;
    logic [1:0]  dbg_state;

    // clock / PRAM model
    always #5 clk = ~clk;
    assign pram_data = pram_addr[7:0] ^ 8'hA5;

    pram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .len0      (len0),
        .len1      (len1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rd_data   (rd_data),
        .rd_valid0 (rd_valid0),
        .rd_valid1 (rd_valid1),
        .done0     (done0),
        .done1     (done1),
        .pram_addr (pram_addr),
        .pram_data (pram_data),
        .dbg_state (dbg_state)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: {client, done, address, data} per byte; {client, gnt cycles} per burst
    logic [25:0] exp_q[$];
    logic [9:0]  gnt_q[$];
    bit          last_m = 1'b1;   // model: client served last (1 after reset)
    bit          check_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Expected bytes of one burst: addresses start..start+len modulo 2^16.
    task automatic push_burst(input bit c, input logic [15:0] a, input logic [7:0] l);
        logic [15:0] ak;
        for (int k = 0; k <= int'(l); k++) begin
            ak = a + 16'(k);
            exp_q.push_back({c, (k == int'(l)), ak, ak[7:0] ^ 8'hA5});
        end
        gnt_q.push_back({c, 9'(l) + 9'd2});
    endtask

    // monitor
    logic [15:0] prev_addr = '0;
    int          gcnt = 0;
    bit          prev_g = 1'b0;
    bit          gcl = 1'b0;
    int          done_cyc = 0;
    logic [25:0] e;
    logic [9:0]  ge;

    always @(negedge clk) begin
        if (rst) begin
            gcnt   = 0;
            prev_g = 1'b0;
        end else begin
            check("exclusive", {29'd0, gnt0 & gnt1, rd_valid0 & rd_valid1, done0 & done1}, 32'd0);
            if (rd_valid0 | rd_valid1) begin
                check("valid_owner", {31'd0, rd_valid1 ? gnt1 : gnt0}, 32'd1);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_byte");
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {6'd0, rd_valid1, rd_valid1 ? done1 : done0, prev_addr, rd_data},
                          {6'd0, e});
                end
            end else begin
                check("done_without_valid", {31'd0, done0 | done1}, 32'd0);
            end
            if (gnt0 | gnt1) begin
                if (!prev_g) begin
                    gcl = gnt1;
                    if (check_gap) check("grant_gap", cyc - done_cyc, 32'd2);
                end
                gcnt++;
            end else if (prev_g) begin
                if (gnt_q.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    ge = gnt_q.pop_front();
                    check("gnt_len", {22'd0, gcl, 9'(gcnt)}, {22'd0, ge});
                end
                gcnt = 0;
            end
            if (done0 | done1) done_cyc = cyc;
            prev_g = gnt0 | gnt1;
        end
        prev_addr = pram_addr;
    end

    // driver tasks
    task automatic wait_gnt(input bit c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                check("gnt_client", {31'd0, gnt1}, {31'd0, c});
                ok = 1'b1;
                return;
            end
        end
        fail_now("gnt_timeout");
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done0 | done1) begin
                ok = 1'b1;
                return;
            end
        end
        fail_now("done_timeout");
    endtask

    task automatic idle_check(input logic [15:0] exp_addr);
        repeat (2) @(negedge clk);
        check("idle_addr_hold", {16'd0, pram_addr}, {16'd0, exp_addr});
        check("idle_quiet", {28'd0, rd_valid0, rd_valid1, done0, done1}, 32'd0);
    endtask

    task automatic run_round(input bit r0, input bit r1,
                             input logic [15:0] a0, input logic [15:0] a1,
                             input logic [7:0] l0, input logic [7:0] l1,
                             input bit scramble);
        bit          order[2];
        int          n;
        bit          ok;
        logic [15:0] fin;
        if (r0 && r1) begin
            order[0] = ~last_m;
            order[1] = last_m;
            n = 2;
        end else begin
            order[0] = r1;
            order[1] = r1;
            n = 1;
        end
        for (int i = 0; i < n; i++)
            push_burst(order[i], order[i] ? a1 : a0, order[i] ? l1 : l0);
        last_m = order[n-1];
        fin = order[n-1] ? a1 + 16'(l1) : a0 + 16'(l0);
        @(negedge clk);
        req0 = r0; addr0 = a0; len0 = l0;
        req1 = r1; addr1 = a1; len1 = l1;
        for (int i = 0; i < n; i++) begin
            wait_gnt(order[i], ok);
            if (order[i]) req1 = 1'b0; else req0 = 1'b0;
            if (scramble) begin
                if (order[i]) begin addr1 = 16'($urandom); len1 = 8'($urandom); end
                else          begin addr0 = 16'($urandom); len0 = 8'($urandom); end
            end
            if (!ok) begin
                req0 = 1'b0; req1 = 1'b0;
                exp_q.delete(); gnt_q.delete();
                return;
            end
            wait_done(ok);
        end
        idle_check(fin);
    endtask

    // Both clients hold req continuously with single-byte bursts.
    task automatic run_held(input int n, input logic [15:0] a0, input logic [15:0] a1);
        bit c;
        int cnt;
        c = ~last_m;
        for (int i = 0; i < n; i++) begin
            push_burst(c, c ? a1 : a0, 8'd0);
            last_m = c;
            c = ~c;
        end
        @(negedge clk);
        req0 = 1'b1; addr0 = a0; len0 = 8'd0;
        req1 = 1'b1; addr1 = a1; len1 = 8'd0;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < n; i++) begin
            @(negedge clk);
            if (done0 | done1) begin
                cnt++;
                check_gap = 1'b1;
                if (cnt == n) begin
                    req0 = 1'b0; req1 = 1'b0;
                    check_gap = 1'b0;
                end
            end
        end
        if (cnt != n) begin
            fail_now("held_timeout");
            req0 = 1'b0; req1 = 1'b0; check_gap = 1'b0;
        end
        idle_check(last_m ? a1 : a0);
    endtask

    // Reset on the third byte of an eight-byte burst.
    task automatic run_reset();
        bit ok;
        int cnt;
        push_burst(1'b0, 16'h4000, 8'd7);
        last_m = 1'b0;
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'h4000; len0 = 8'd7;
        wait_gnt(1'b0, ok);
        req0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20 && cnt < 3; i++) begin
            @(negedge clk);
            if (rd_valid0) cnt++;
        end
        check("reset_third_byte_seen", cnt, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctrl", {25'd0, gnt0, gnt1, rd_valid0, rd_valid1, done0, done1, 1'b0}, 32'd0);
        check("abort_data", {8'd0, rd_data, pram_addr}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        exp_q.delete();
        gnt_q.delete();
        last_m = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // stimulus
    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {26'd0, gnt0, gnt1, rd_valid0, rd_valid1, done0, done1}, 32'd0);
        check("reset_data", {8'd0, rd_data, pram_addr}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;

        run_round(1'b1, 1'b1, 16'h0040, 16'h0100, 8'd2, 8'd0, 1'b0);  // tie after reset
        run_round(1'b1, 1'b0, 16'h0000, 16'h0000, 8'd3, 8'd0, 1'b0);  // A5,A4,A7,A6
        run_round(1'b0, 1'b1, 16'h0000, 16'hFFFE, 8'd0, 8'd3, 1'b0);  // address wrap
        run_round(1'b1, 1'b0, 16'h1230, 16'h0000, 8'd5, 8'd0, 1'b1);  // inputs change mid-burst
        run_held(4, 16'h2000, 16'h3000);
        run_reset();
        run_round(1'b1, 1'b1, 16'h5000, 16'h6000, 8'd1, 8'd2, 1'b0);  // tie after mid-burst reset
        run_round(1'b0, 1'b1, 16'h0000, 16'hFF80, 8'd0, 8'd255, 1'b0); // longest burst
        for (int i = 0; i < 25; i++) begin
            int r;
            r = $urandom_range(1, 3);
            run_round(r[0], r[1], 16'($urandom), 16'($urandom),
                      8'($urandom_range(0, 12)), 8'($urandom_range(0, 12)),
                      1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("bytes_left", exp_q.size(), 32'd0);
        check("grants_left", gnt_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time limit
    initial begin
        #400000;
        $display("FAIL global_timeout");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pram_arbiter.md
PRAM_ARBITER -- requirements
Module: pram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, PRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, PRAM data width.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0, req1  input  1 each  burst request from client 0/1.
REQ-007 addr0, addr1  input  ADDR_W each  burst start address.
REQ-008 len0, len1  input  LEN_W each  burst length minus one (0 = 1 byte, 255 = 256 bytes).
REQ-009 gnt0, gnt1  output  1 each  client owns the PRAM.
REQ-010 rd_data  output  DATA_W  registered PRAM read data.
REQ-011 rd_valid0, rd_valid1  output  1 each  rd_data valid for client 0/1.
REQ-012 done0, done1  output  1 each  one-cycle end-of-burst pulse.
REQ-013 pram_addr  output  ADDR_W  address to the combinational PRAM.
REQ-014 pram_data  input  DATA_W  PRAM read data, valid in the same cycle as pram_addr.

Function
REQ-015 States SHALL be IDLE, BURST and FLUSH.
REQ-016 IDLE: if any req is high at an edge, go to BURST, latch the winner's addr/len into the address counter and the remaining-count register, and set its gnt.
REQ-017 Arbitration SHALL be round-robin: a single requester wins; on simultaneous requests the client not served last wins; after reset client 0 wins a tie.
REQ-018 BURST: pram_addr = start + k for k = 0..len, one per cycle; the counter SHALL wrap from all-ones to 0.
REQ-019 rd_data SHALL be pram_data registered, with the owner's rd_valid asserted one cycle after the corresponding pram_addr (1-cycle latency, one byte per cycle, no gaps).
REQ-020 After the cycle that presents address start+len, go to FLUSH; FLUSH SHALL output the last byte with rd_valid and assert the owner's done in that same cycle, then return to IDLE.
REQ-021 gnt SHALL be high from the cycle after the grant edge through FLUSH inclusive; at most one gnt, one rd_valid and one done SHALL be high in any cycle.
REQ-022 A new grant SHALL NOT be made in FLUSH; the minimum gap between one done and the next grant's first address is one IDLE cycle.
REQ-023 addr/len SHALL be sampled only on the grant edge; later changes and deassertion of req during a burst SHALL be ignored (the burst completes).
REQ-024 A client holding req high after its done SHALL be treated as a new request, subject to round-robin.
REQ-025 In IDLE, pram_addr SHALL hold its last value, and rd_valid/done SHALL be low.

Reset
REQ-026 When rst is high at an edge: state = IDLE; gnt, rd_valid and done = 0; rd_data = 0; pram_addr = 0; the round-robin pointer favours client 0.
REQ-027 Reset mid-burst SHALL abort the burst with no done pulse; the first grant after reset SHALL follow REQ-017.

Structure
REQ-028 The shared package pram_pkg SHALL hold the ADDR_W/DATA_W/LEN_W defaults and the state encoding constants.
REQ-029 The two-way round-robin picker SHALL be the sub-module pram_rr_arb (inputs: req pair and last-served flag; output: one-hot winner); the FSM, counters and data register stay in pram_arbiter.

Verification (bench PRAM model: data = addr[7:0] ^ 8'hA5)
REQ-030 req0, addr0=16'h0000, len0=3 -> gnt0 high 5 cycles; rd_valid0 carries A5,A4,A7,A6 on consecutive cycles; done0 with A6.
REQ-031 req0 and req1 rise on the same edge after reset (addr1=16'h0100, len1=0) -> client 0 served first, then client 1 gets one byte A5 with done1; no overlap of gnt0/gnt1.
REQ-032 Both held high continuously, len=0 each -> grants alternate 0,1,0,1, with one IDLE cycle between each done and the next grant's first address.
REQ-033 addr1=16'hFFFE, len1=3 -> pram_addr sequence FFFE, FFFF, 0000, 0001; data 5B,5A,A5,A4.
REQ-034 rst pulsed on the 3rd byte of a len=7 burst -> all outputs 0 next cycle, no done; a subsequent request is served from its own start address.
REQ-035 req0 dropped and addr0 changed mid-burst -> burst completes with the original addresses and done0 fires.
